// File: rtl/gpio_mode_serial_loader_if.sv
// Serial configuration bus between a DM-code source and the
// GPIO mode loader; the master shifts codes in, the slave commits them.
interface gpio_mode_serial_loader_if #(
    parameter int NUM_PADS = 2
);
    localparam int W = 3 * NUM_PADS;

    logic                ser_valid;
    logic                ser_data;
    logic                load;
    logic [W-1:0]        dm;
    logic                ser_out;
    logic                busy;
    logic                load_ok;
    logic                load_err;
    logic [NUM_PADS-1:0] bad_code;

    modport master (
        output ser_valid,
        output ser_data,
        output load,
        input  dm,
        input  ser_out,
        input  busy,
        input  load_ok,
        input  load_err,
        input  bad_code
    );

    modport slave (
        input  ser_valid,
        input  ser_data,
        input  load,
        output dm,
        output ser_out,
        output busy,
        output load_ok,
        output load_err,
        output bad_code
    );
endinterface

// File: rtl/gpio_mode_serial_loader.sv
// Bit-serial shadow register of per-pad DM codes with atomic,
// sanitised commit to the pad wrappers.
module gpio_mode_serial_loader #(
    parameter int         NUM_PADS   = 2,
    parameter logic [2:0] DEFAULT_DM = 3'b001
) (
    input  logic                       clk,
    input  logic                       rst,
    gpio_mode_serial_loader_if.slave   bus
);
    localparam int W  = 3 * NUM_PADS;
    localparam int CW = $clog2(W + 2);

    localparam logic [CW-1:0] C_LAST = CW'(W - 1);
    localparam logic [CW-1:0] C_FULL = CW'(W);
    localparam logic [CW-1:0] C_OVER = CW'(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FULL,
        S_OVER
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic [W-1:0]        r_shadow;
    logic [W-1:0]        r_dm;
    logic                r_ser_out;
    logic                r_busy;
    logic                r_load_ok;
    logic                r_load_err;
    logic [NUM_PADS-1:0] r_bad_code;

    logic [W-1:0]        w_clean;
    logic [NUM_PADS-1:0] w_supported;

    // Unsupported codes fall back to the safe mode and raise a per-pad flag.
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
        logic [2:0] w_code;
        assign w_code = r_shadow[3*gi +: 3];
        assign w_supported[gi] = (w_code == 3'b001) ||
                                 (w_code == 3'b010) ||
                                 (w_code == 3'b011) ||
                                 (w_code == 3'b110);
        assign w_clean[3*gi +: 3] = w_supported[gi] ? w_code : DEFAULT_DM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_shadow   <= '0;
            r_dm       <= {NUM_PADS{DEFAULT_DM}};
            r_ser_out  <= 1'b0;
            r_busy     <= 1'b0;
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
            r_bad_code <= '0;
        end else begin
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
            if (bus.load) begin
                // load wins over a coincident serial bit
                if (r_state == S_FULL) begin
                    r_dm       <= w_clean;
                    r_bad_code <= ~w_supported;
                    r_load_ok  <= 1'b1;
                end else begin
                    r_load_err <= 1'b1;
                end
                r_count <= '0;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else if (bus.ser_valid) begin
                r_shadow  <= {r_shadow[W-2:0], bus.ser_data};
                r_ser_out <= r_shadow[W-1];
                r_busy    <= 1'b1;
                if (r_count != C_OVER) begin
                    r_count <= r_count + 1'b1;
                end
                case (r_state)
                    S_IDLE:  r_state <= (C_LAST == '0) ? S_FULL : S_SHIFT;
                    S_SHIFT: r_state <= (r_count == C_LAST) ? S_FULL
                                                            : S_SHIFT;
                    S_FULL:  r_state <= S_OVER;
                    S_OVER:  r_state <= S_OVER;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.dm       = r_dm;
    assign bus.ser_out  = r_ser_out;
    assign bus.busy     = r_busy;
    assign bus.load_ok  = r_load_ok;
    assign bus.load_err = r_load_err;
    assign bus.bad_code = r_bad_code;

    logic w_unused;
    assign w_unused = ^{C_FULL};
endmodule

// File: tb/tb_gpio_mode_serial_loader.sv
// Directed bench for the GPIO mode loader with a frame-level
// reference model checked every cycle.
module tb_gpio_mode_serial_loader;
    localparam int NP = 2;
    localparam int W  = 3 * NP;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst;

    gpio_mode_serial_loader_if #(.NUM_PADS(NP)) bus ();

    gpio_mode_serial_loader #(
        .NUM_PADS  (NP),
        .DEFAULT_DM(3'b001)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // model state: all bits shifted since reset, bits since last load
    bit          hist[$];
    int          nbits;
    logic [W-1:0] m_dm;
    logic [NP-1:0] m_bad;
    logic        m_ok, m_err, m_ser, m_busy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] fix(input logic [2:0] c);
        if (c inside {3'b001, 3'b010, 3'b011, 3'b110}) return c;
        return 3'b001;
    endfunction

    task automatic model_reset();
        hist.delete();
        nbits  = 0;
        m_dm   = {NP{3'b001}};
        m_bad  = '0;
        m_ok   = 0;
        m_err  = 0;
        m_ser  = 0;
        m_busy = 0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit l);
        logic [W-1:0] frame;
        m_ok  = 0;
        m_err = 0;
        if (l) begin
            if (nbits == W) begin
                frame = '0;
                for (int k = 0; k < W; k++)
                    frame[k] = hist[hist.size() - 1 - k];
                for (int p = 0; p < NP; p++) begin
                    m_dm[3*p +: 3] = fix(frame[3*p +: 3]);
                    m_bad[p] = (fix(frame[3*p +: 3]) != frame[3*p +: 3]) ||
                               (frame[3*p +: 3] == 3'b000);
                end
                m_ok = 1;
            end else begin
                m_err = 1;
            end
            nbits = 0;
        end else if (v) begin
            m_ser = (hist.size() >= W) ? hist[hist.size() - W] : 1'b0;
            hist.push_back(d);
            nbits++;
        end
        m_busy = (nbits != 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("dm", bus.dm, m_dm);
            chk("ser_out", bus.ser_out, m_ser);
            chk("busy", bus.busy, m_busy);
            chk("load_ok", bus.load_ok, m_ok);
            chk("load_err", bus.load_err, m_err);
            chk("bad_code", bus.bad_code, m_bad);
            chk("ok_err_excl", bus.load_ok & bus.load_err, 0);
        end
    end

    task automatic cyc(input bit v, input bit d, input bit l);
        bus.ser_valid = v;
        bus.ser_data  = d;
        bus.load      = l;
        @(posedge clk);
        model_step(v, d, l);
        @(negedge clk);
        bus.ser_valid = 0;
        bus.ser_data  = 0;
        bus.load      = 0;
    endtask

    task automatic frame(input logic [W-1:0] f);
        logic [W-1:0] t;
        t = f;
        for (int k = W - 1; k >= 0; k--) cyc(1, t[k], 0);
    endtask

    task automatic pulse_rst();
        rst = 1;
        model_reset();
        #2;
        rst = 0;
    endtask

    initial begin
        bus.ser_valid = 0;
        bus.ser_data  = 0;
        bus.load      = 0;
        rst = 1;
        model_reset();
        #1;
        chk("rst_dm", bus.dm, 6'b001001);
        chk("rst_ser_out", bus.ser_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bad", bus.bad_code, 0);
        chk("rst_ok_err", {bus.load_ok, bus.load_err}, 0);
        clk_en = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) cyc(0, 0, 0);
        chk("idle_dm", bus.dm, 6'b001001);

        frame(6'b110010);
        chk("good_busy", bus.busy, 1);
        cyc(0, 0, 1);
        chk("good_dm", bus.dm, 6'b110010);
        chk("good_ok", bus.load_ok, 1);
        chk("good_busy0", bus.busy, 0);
        cyc(0, 0, 0);
        chk("good_ok_gone", bus.load_ok, 0);

        for (int k = 0; k < 5; k++) cyc(1, k[0], 0);
        cyc(0, 0, 1);
        chk("short_err", bus.load_err, 1);
        chk("short_dm", bus.dm, 6'b110010);
        chk("short_busy", bus.busy, 0);
        cyc(0, 0, 1);
        chk("idle_load_err", bus.load_err, 1);
        cyc(0, 0, 0);

        pulse_rst();
        cyc(0, 0, 0);
        cyc(1, 1, 0);
        for (int k = 0; k < 6; k++) cyc(1, 0, 0);
        chk("over_ser_out", bus.ser_out, 1);
        cyc(0, 0, 1);
        chk("over_err", bus.load_err, 1);
        chk("over_dm", bus.dm, 6'b001001);

        frame(6'b111011);
        cyc(0, 0, 1);
        chk("bad_dm", bus.dm, 6'b001011);
        chk("bad_flags", bus.bad_code, 2'b10);
        chk("bad_ok", bus.load_ok, 1);

        frame(6'b110010);
        cyc(1, 1, 1);
        chk("coll_ok", bus.load_ok, 1);
        chk("coll_dm", bus.dm, 6'b110010);
        chk("coll_bad", bus.bad_code, 2'b00);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("coll_chain", bus.ser_out, 1);
        cyc(1, 0, 0);
        pulse_rst();
        cyc(0, 0, 0);
        chk("mid_rst_dm", bus.dm, 6'b001001);
        chk("mid_rst_busy", bus.busy, 0);
        frame(6'b010011);
        cyc(0, 0, 1);
        chk("final_dm", bus.dm, 6'b010011);
        chk("final_ok", bus.load_ok, 1);
        cyc(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
